// File: rtl/msrv32_dbus_pkg.sv
// msrv32_dbus_pkg: shared encodings for the data-bus controller
package msrv32_dbus_pkg;
  localparam logic [1:0] BYTE = 2'b00;
  localparam logic [1:0] HALF = 2'b01;
  localparam logic [1:0] WORD = 2'b10;
  localparam logic [1:0] HTRANS_IDLE = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_ERR} state_t;
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] a);
    return (size[1] && a != 2'b00) || (size == HALF && a[0]);
  endfunction
endpackage

// File: rtl/msrv32_store_align.sv
// msrv32_store_align: store lane replication and byte write mask
module msrv32_store_align (
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_addr,
  input  logic [31:0] i_rs2,
  output logic [31:0] o_wdata,
  output logic [3:0]  o_mask
);
  import msrv32_dbus_pkg::*;
  always_comb begin
    o_wdata = i_size == BYTE ? {4{i_rs2[7:0]}} : i_size == HALF ? {2{i_rs2[15:0]}} : i_rs2;
    o_mask  = i_size == BYTE ? 4'b0001 << i_addr : i_size == HALF ? 4'b0011 << {i_addr[1], 1'b0} : 4'b1111;
  end
endmodule

// File: rtl/msrv32_dbus_ctrl.sv
// msrv32_dbus_ctrl: single-outstanding AHB-Lite data master for core loads and stores
module msrv32_dbus_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              ms_riscv32_mp_clk_in,
  input  logic              ms_riscv32_mp_rst_n_in,
  input  logic              mem_req_in,
  input  logic              mem_we_in,
  input  logic [ADDR_W-1:0] mem_addr_in,
  input  logic [1:0]        mem_size_in,
  input  logic              mem_unsigned_in,
  input  logic [DATA_W-1:0] rs2_in,
  output logic              mem_done_out,
  output logic              stall_out,
  output logic              misaligned_out,
  output logic              bus_err_out,
  output logic [ADDR_W-1:0] haddr_out,
  output logic [1:0]        htrans_out,
  output logic              hwrite_out,
  output logic [2:0]        hsize_out,
  output logic [DATA_W-1:0] hwdata_out,
  output logic [3:0]        dmwr_mask_out,
  input  logic              hready_in,
  input  logic              hresp_in,
  input  logic [DATA_W-1:0] hrdata_in,
  output logic [DATA_W-1:0] dmdata_out,
  output logic              ahb_resp_out,
  output logic [1:0]        iadder_1_to_0_out,
  output logic [1:0]        load_size_out,
  output logic              load_unsigned_out
);
  import msrv32_dbus_pkg::*;
  state_t r_state, w_next;
  logic r_unsigned;
  logic [1:0] w_size;
  logic [DATA_W-1:0] w_wdata;
  logic [3:0] w_mask;
  logic w_accept, w_mis, w_ok, w_err;
  assign w_size   = mem_size_in == 2'b11 ? WORD : mem_size_in;
  assign w_mis    = misaligned(w_size, mem_addr_in[1:0]);
  assign w_accept = r_state == S_IDLE && mem_req_in && !mem_done_out;
  assign w_ok     = r_state == S_DATA && hready_in && !hresp_in;
  assign w_err    = hready_in && ((r_state == S_DATA && hresp_in) || r_state == S_ERR);
  assign stall_out = ms_riscv32_mp_rst_n_in && (r_state != S_IDLE || (mem_req_in && !mem_done_out));
  msrv32_store_align u_align (
    .i_size (w_size),
    .i_addr (mem_addr_in[1:0]),
    .i_rs2  (rs2_in),
    .o_wdata(w_wdata),
    .o_mask (w_mask)
  );
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: w_next = (w_accept && !w_mis) ? S_ADDR : S_IDLE;
      S_ADDR: w_next = hready_in ? S_DATA : S_ADDR;
      S_DATA: w_next = hready_in ? S_IDLE : (hresp_in ? S_ERR : S_DATA);
      S_ERR:  w_next = hready_in ? S_IDLE : S_ERR;
    endcase
  end
  always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in)
    if (!ms_riscv32_mp_rst_n_in) r_state <= S_IDLE;
    else r_state <= w_next;
  always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
    if (!ms_riscv32_mp_rst_n_in) begin
      mem_done_out      <= 1'b0;
      misaligned_out    <= 1'b0;
      bus_err_out       <= 1'b0;
      ahb_resp_out      <= 1'b0;
      haddr_out         <= '0;
      htrans_out        <= HTRANS_IDLE;
      hwrite_out        <= 1'b0;
      hsize_out         <= '0;
      hwdata_out        <= '0;
      dmwr_mask_out     <= '0;
      dmdata_out        <= '0;
      iadder_1_to_0_out <= '0;
      load_size_out     <= '0;
      load_unsigned_out <= 1'b0;
      r_unsigned        <= 1'b0;
    end else begin
      mem_done_out   <= (w_accept && w_mis) || w_ok || w_err;
      misaligned_out <= w_accept && w_mis;
      bus_err_out    <= w_err;
      ahb_resp_out   <= w_err;
      if (w_accept && !w_mis) begin
        haddr_out     <= mem_addr_in;
        htrans_out    <= HTRANS_NONSEQ;
        hwrite_out    <= mem_we_in;
        hsize_out     <= {1'b0, w_size};
        dmwr_mask_out <= mem_we_in ? w_mask : 4'b0000;
        r_unsigned    <= mem_unsigned_in;
      end
      if (r_state == S_ADDR && hready_in) begin
        htrans_out <= HTRANS_IDLE;
        hwdata_out <= hwrite_out ? w_wdata : '0;
      end
      if (w_ok || w_err) hwdata_out <= '0;
      if (w_ok && !hwrite_out) dmdata_out <= hrdata_in;
      if ((w_ok || w_err) && !hwrite_out) begin
        iadder_1_to_0_out <= haddr_out[1:0];
        load_size_out     <= hsize_out[1:0];
        load_unsigned_out <= r_unsigned;
      end
    end
  end
endmodule
